hack_sys_sequencer: RTL and testbench
=====================================

// Module: hack_sys_sequencer
// PURPOSE
//  Top-level sequencer for the HACK computer: loads a program into instruction memory from a host stream,
//  sweeps data memory to zero, then runs, halts or resumes the CPU via reset and clock-enable.
//  Sits between host and the memories/CPU; owns every host-side write port.
//  Single clock domain; the CPU is advanced by a clock-enable, never by a divided clock.
// PARAMETERS
//  ADDR_W     15      memory address width (instruction and data)
//  DATA_W     16      memory word width
//  CLR_DEPTH  32768   data-memory words zeroed by CLEAR (1..2**ADDR_W)
//  CPU_DIV    2       system clocks per CPU step in RUN (>=1)
// PORTS
//  clock       in   1       system clock, all logic on rising edge
//  reset       in   1       asynchronous, active-high reset
//  cmd_load    in   1       1-cycle pulse: start program load
//  cmd_clear   in   1       1-cycle pulse: zero data memory
//  cmd_run     in   1       1-cycle pulse: run/resume CPU
//  cmd_halt    in   1       1-cycle pulse: halt CPU / abort LOAD or CLEAR
//  ld_valid    in   1       host load word valid
//  ld_data     in   DATA_W  host load word
//  ld_last     in   1       qualifies final word of program
//  ld_ready    out  1       sequencer accepts load word
//  imem_wren   out  1       instruction-memory write strobe
//  imem_addr   out  ADDR_W  instruction-memory write address
//  imem_wdata  out  DATA_W  instruction-memory write data
//  dmem_wren   out  1       data-memory write strobe (CLEAR only)
//  dmem_addr   out  ADDR_W  data-memory write address
//  cpu_rst     out  1       holds CPU in reset
//  cpu_ce      out  1       CPU clock-enable pulse
//  state       out  3       current state encoding
//  busy        out  1       high in LOAD or CLEAR
//  load_err    out  1       sticky: program overflowed instruction memory
//  load_count  out  ADDR_W+1 words written by last/current load
// BEHAVIOUR
//  Reset: state=IDLE, cpu_rst=1, all other outputs 0 (counters, addr, data, err cleared).
//  States: IDLE=0 LOAD=1 CLEAR=2 RUN=3 HALT=4. Same-cycle command priority: halt > clear > load > run.
//  IDLE/HALT: load->LOAD, clear->CLEAR, run->RUN; halt ignored. RUN: halt->HALT, others ignored.
//  LOAD/CLEAR: only halt honoured -> IDLE (abort); other commands ignored.
//  Entering LOAD: addr=0, load_count=0, load_err=0. ld_ready=1 only while in LOAD.
//  Handshake ld_valid&ld_ready: next cycle imem_wren=1 for exactly 1 cycle, imem_addr/wdata = address/word.
//  Address increments per handshake; ld_last -> IDLE after that write. Handshake at addr 2**ADDR_W-1
//  without ld_last -> write it, set load_err, -> IDLE. A write registered before abort still completes.
//  load_count saturates at 2**ADDR_W; holds value until next LOAD.
//  CLEAR: dmem_wren=1 each cycle, dmem_addr 0..CLR_DEPTH-1 (write data is zero), then IDLE; CLR_DEPTH cycles.
//  cpu_rst=1 in IDLE/LOAD/CLEAR, 0 in RUN/HALT (HALT freezes CPU state, resumable).
//  RUN: prescaler starts at 0 on entry; cpu_ce=1 for 1 cycle every CPU_DIV cycles, first pulse
//  on the CPU_DIV-th cycle in RUN; CPU_DIV=1 gives cpu_ce continuously high. cpu_ce=0 outside RUN.
//  Reset mid-operation: immediate return to reset values; partial loads are not recovered.
// CONFIGURATION
//  HACK_CYCLE_CNT_EN defined: adds port run_cycles out 32 = count of cpu_ce pulses since last LOAD
//  entry; wraps at 2**32; cleared by reset. Undefined: port and counter absent, no other change.
// STRUCTURE
//  Package hack_seq_pkg: state enum (5 values, 3 bits), ADDR_W/DATA_W defaults, command-priority constants.
//  One sub-module: hack_ce_gen (CPU_DIV prescaler; inputs enable and restart; output ce pulse).
//  FSM, load address counter and clear counter stay in the top.
// TESTING
//  Load 3 words (0x1111,0x2222,0x3333 last), valid each cycle -> imem writes at addr 0,1,2 one cycle
//    after each handshake; IDLE; load_count=3; load_err=0.
//  ADDR_W=4 load 16 words, no ld_last -> 16 writes, load_err=1, IDLE, load_count=16.
//  cmd_clear with CLR_DEPTH=8 -> dmem_wren high 8 cycles, addr 0..7, busy high, then IDLE.
//  cmd_run with CPU_DIV=2 -> cpu_rst falls on entry, cpu_ce on cycles 2,4,6; cmd_halt -> cpu_ce 0,
//    cpu_rst 0; cmd_run again -> first ce 2 cycles later.
//  cmd_halt and cmd_clear same cycle in HALT -> CLEAR not entered, state stays HALT (halt ignored there,
//    but priority blocks clear); repeat with clear only -> CLEAR.
//  reset asserted mid-LOAD after 2 words -> IDLE, cpu_rst=1, load_count=0, no further imem writes.

Source files
------------

// File: rtl/hack_sys_sequencer_pkg.sv
// Shared types, defaults and command-priority helper for the HACK system sequencer.
package hack_seq_pkg;

    localparam int unsigned DEF_ADDR_W = 15;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Decoded command after same-cycle arbitration; halt > clear > load > run.
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_HALT  = 3'd1,
        CMD_CLEAR = 3'd2,
        CMD_LOAD  = 3'd3,
        CMD_RUN   = 3'd4
    } cmd_t;

    function automatic cmd_t pick_cmd(input logic halt, input logic clear,
                                      input logic load, input logic run);
        if (halt)  return CMD_HALT;
        if (clear) return CMD_CLEAR;
        if (load)  return CMD_LOAD;
        if (run)   return CMD_RUN;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/hack_sys_sequencer_if.sv
// Host load stream plus instruction/data memory write ports of the HACK sequencer.
interface hack_sys_sequencer_if
    import hack_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              dmem_wren;
    logic [ADDR_W-1:0] dmem_addr;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, imem_wren, imem_addr, imem_wdata, dmem_wren, dmem_addr
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, imem_wren, imem_addr, imem_wdata, dmem_wren, dmem_addr
    );
endinterface

// File: rtl/hack_sys_sequencer_ce_gen.sv
// CPU clock-enable prescaler: one ce pulse every CPU_DIV enabled cycles, restartable.
module hack_ce_gen #(
    parameter int unsigned CPU_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic ce
);
    localparam int unsigned CW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPU_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign ce = enable && (cnt_q == LAST);
endmodule

// File: rtl/hack_sys_sequencer.sv
// HACK system sequencer: program load, data-memory clear, CPU run/halt control.
// Optional HACK_CYCLE_CNT_EN adds the run_cycles port counting cpu_ce pulses.
module hack_sys_sequencer
    import hack_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CLR_DEPTH = 32768,
    parameter int unsigned CPU_DIV   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_load,
    input  logic                cmd_clear,
    input  logic                cmd_run,
    input  logic                cmd_halt,
    hack_sys_sequencer_if.slave bus,
    output logic                cpu_rst,
    output logic                cpu_ce,
    output logic [2:0]          state,
    output logic                busy,
    output logic                load_err,
    output logic [ADDR_W:0]     load_count
`ifdef HACK_CYCLE_CNT_EN
    ,
    output logic [31:0]         run_cycles
`endif
);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W:0]   LCNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CLR_DEPTH - 1);

    state_t            state_q, state_n;
    cmd_t              cmd;
    logic              hs;
    logic              load_entry;
    logic              run_entry;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] clr_q;
    logic              imem_wren_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [DATA_W-1:0] imem_wdata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        cmd     = pick_cmd(cmd_halt, cmd_clear, cmd_load, cmd_run);
        hs      = bus.ld_valid && (state_q == ST_LOAD);
        state_n = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                // A halt in IDLE/HALT does nothing itself but still outranks the others.
                case (cmd)
                    CMD_CLEAR: state_n = ST_CLEAR;
                    CMD_LOAD:  state_n = ST_LOAD;
                    CMD_RUN:   state_n = ST_RUN;
                    default:   state_n = state_q;
                endcase
            end
            ST_LOAD: begin
                if (cmd == CMD_HALT)
                    state_n = ST_IDLE;
                else if (hs && (bus.ld_last || addr_q == ADDR_MAX))
                    state_n = ST_IDLE;
            end
            ST_CLEAR: begin
                if (cmd == CMD_HALT || clr_q == CLR_LAST)
                    state_n = ST_IDLE;
            end
            ST_RUN: begin
                if (cmd == CMD_HALT)
                    state_n = ST_HALT;
            end
            default: state_n = ST_IDLE;
        endcase
        load_entry = (state_n == ST_LOAD) && (state_q != ST_LOAD);
        run_entry  = (state_n == ST_RUN)  && (state_q != ST_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            clr_q        <= '0;
            load_count   <= '0;
            load_err     <= 1'b0;
            imem_wren_q  <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            imem_wren_q <= 1'b0;
            if (load_entry) begin
                addr_q     <= '0;
                load_count <= '0;
                load_err   <= 1'b0;
            end else if (hs) begin
                imem_wren_q  <= 1'b1;
                imem_addr_q  <= addr_q;
                imem_wdata_q <= bus.ld_data;
                addr_q       <= addr_q + ADDR_W'(1);
                if (load_count != LCNT_MAX)
                    load_count <= load_count + (ADDR_W+1)'(1);
                if (addr_q == ADDR_MAX && !bus.ld_last)
                    load_err <= 1'b1;
            end
            clr_q <= (state_q == ST_CLEAR && state_n == ST_CLEAR) ? clr_q + ADDR_W'(1) : '0;
        end
    end

    hack_ce_gen #(.CPU_DIV(CPU_DIV)) u_ce_gen (
        .clock   (clock),
        .reset   (reset),
        .enable  (state_q == ST_RUN),
        .restart (run_entry),
        .ce      (cpu_ce)
    );

`ifdef HACK_CYCLE_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           run_cycles <= '0;
        else if (load_entry) run_cycles <= '0;
        else if (cpu_ce)     run_cycles <= run_cycles + 32'd1;
    end
`endif

    assign state          = state_q;
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_CLEAR);
    assign cpu_rst        = !((state_q == ST_RUN) || (state_q == ST_HALT));
    assign bus.ld_ready   = (state_q == ST_LOAD);
    assign bus.imem_wren  = imem_wren_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.dmem_wren  = (state_q == ST_CLEAR);
    assign bus.dmem_addr  = clr_q;
endmodule

// File: tb/tb_hack_sys_sequencer.sv
// Scoreboard bench for hack_sys_sequencer (ADDR_W=4, CLR_DEPTH=8, CPU_DIV=2).
module tb_hack_sys_sequencer;
    import hack_seq_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } iw_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_load = 1'b0, cmd_clear = 1'b0, cmd_run = 1'b0, cmd_halt = 1'b0;
    logic          cpu_rst, cpu_ce, busy, load_err;
    logic [2:0]    state;
    logic [AW:0]   load_count;
`ifdef HACK_CYCLE_CNT_EN
    logic [31:0]   run_cycles;
`endif

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            c0;
    iw_t           exp_imem[$];
    int            exp_dmem[$];
    int            exp_ce[$];
    iw_t           mon_iw;
    int            mon_v;

    hack_sys_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    hack_sys_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .CLR_DEPTH(8), .CPU_DIV(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_load   (cmd_load),
        .cmd_clear  (cmd_clear),
        .cmd_run    (cmd_run),
        .cmd_halt   (cmd_halt),
        .bus        (bus),
        .cpu_rst    (cpu_rst),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .busy       (busy),
        .load_err   (load_err),
        .load_count (load_count)
`ifdef HACK_CYCLE_CNT_EN
        ,
        .run_cycles (run_cycles)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: every write strobe or ce pulse must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.imem_wren) begin
                if (exp_imem.size() == 0) begin
                    chk("imem_unexpected_write", {28'd0, bus.imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_iw = exp_imem.pop_front();
                    chk("imem_addr", {28'd0, bus.imem_addr}, {28'd0, mon_iw.addr});
                    chk("imem_wdata", {16'd0, bus.imem_wdata}, {16'd0, mon_iw.data});
                end
            end
            if (bus.dmem_wren) begin
                if (exp_dmem.size() == 0) begin
                    chk("dmem_unexpected_write", {28'd0, bus.dmem_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_v = exp_dmem.pop_front();
                    chk("dmem_addr", {28'd0, bus.dmem_addr}, mon_v);
                end
            end
            if (cpu_ce) begin
                if (exp_ce.size() == 0) begin
                    chk("cpu_ce_unexpected", cyc, 32'hFFFF_FFFF);
                end else begin
                    mon_v = exp_ce.pop_front();
                    chk("cpu_ce_cycle", cyc, mon_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        tick(3);
        chk("rst_state", state, ST_IDLE);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_cpu_ce", cpu_ce, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_imem_addr", bus.imem_addr, 0);
        chk("rst_dmem_wren", bus.dmem_wren, 0);
        reset = 1'b0;
        tick(2);
        chk("idle_ld_ready", bus.ld_ready, 0);

        // Three-word program, last word flagged.
        exp_imem.push_back('{addr: 4'd0, data: 16'h1111});
        exp_imem.push_back('{addr: 4'd1, data: 16'h2222});
        exp_imem.push_back('{addr: 4'd2, data: 16'h3333});
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        chk("load_state", state, ST_LOAD);
        chk("load_busy", busy, 1);
        chk("load_ld_ready", bus.ld_ready, 1);
        bus.ld_valid = 1'b1; bus.ld_data = 16'h1111; tick();
        bus.ld_data = 16'h2222; tick();
        bus.ld_data = 16'h3333; bus.ld_last = 1'b1; tick();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("load3_state", state, ST_IDLE);
        chk("load3_count", load_count, 3);
        chk("load3_err", load_err, 0);
        tick(2);

        // Overflow: 16 words into a 16-word memory without ld_last.
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_imem.push_back('{addr: AW'(i), data: DW'(16'hA000 + i)});
            bus.ld_data = DW'(16'hA000 + i);
            tick();
        end
        chk("ovf_state", state, ST_IDLE);
        chk("ovf_err", load_err, 1);
        chk("ovf_count", load_count, 16);
        tick(2);
        bus.ld_valid = 1'b0;
        chk("ovf_count_hold", load_count, 16);

        // CLEAR sweeps 8 addresses.
        for (int i = 0; i < 8; i++) exp_dmem.push_back(i);
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        chk("clr_state", state, ST_CLEAR);
        chk("clr_busy", busy, 1);
        chk("clr_cpu_rst", cpu_rst, 1);
        tick(7);
        chk("clr_last_cycle_state", state, ST_CLEAR);
        tick();
        chk("clr_done_state", state, ST_IDLE);
        chk("clr_done_busy", busy, 0);
        tick(2);

        // RUN with CPU_DIV=2, halt, resume.
        c0 = cyc;
        exp_ce.push_back(c0 + 2); exp_ce.push_back(c0 + 4); exp_ce.push_back(c0 + 6);
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        chk("run_state", state, ST_RUN);
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_first_cycle_ce", cpu_ce, 0);
        tick(5);
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        chk("halt_state", state, ST_HALT);
        chk("halt_cpu_rst", cpu_rst, 0);
        tick(4);
        c0 = cyc;
        exp_ce.push_back(c0 + 2); exp_ce.push_back(c0 + 4);
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        chk("resume_state", state, ST_RUN);
        tick(3);
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        chk("halt2_state", state, ST_HALT);
        tick(3);

        // Halt outranks clear even where halt itself is ignored.
        cmd_halt = 1'b1; cmd_clear = 1'b1; tick(); cmd_halt = 1'b0; cmd_clear = 1'b0;
        chk("prio_state", state, ST_HALT);
        tick(2);
        for (int i = 0; i < 8; i++) exp_dmem.push_back(i);
        cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
        chk("halt_clear_state", state, ST_CLEAR);
        chk("halt_clear_cpu_rst", cpu_rst, 1);
        tick(8);
        chk("halt_clear_done", state, ST_IDLE);

        // Reset in the middle of a load.
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        chk("reload_err_cleared", load_err, 0);
        chk("reload_count_cleared", load_count, 0);
        exp_imem.push_back('{addr: 4'd0, data: 16'h5555});
        exp_imem.push_back('{addr: 4'd1, data: 16'h6666});
        bus.ld_valid = 1'b1; bus.ld_data = 16'h5555; tick();
        bus.ld_data = 16'h6666; tick();
        bus.ld_valid = 1'b0; tick();
        chk("midload_count", load_count, 2);
        bus.ld_valid = 1'b1; bus.ld_data = 16'h7777;
        reset = 1'b1;
        #1;
        chk("midrst_state", state, ST_IDLE);
        chk("midrst_cpu_rst", cpu_rst, 1);
        chk("midrst_count", load_count, 0);
        tick(2);
        reset = 1'b0;
        tick(4);
        bus.ld_valid = 1'b0;
        chk("postrst_state", state, ST_IDLE);
        chk("postrst_count", load_count, 0);

        chk("imem_queue_drained", exp_imem.size(), 0);
        chk("dmem_queue_drained", exp_dmem.size(), 0);
        chk("ce_queue_drained", exp_ce.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
